// File: rtl/muldiv_unit.sv
// muldiv_unit: owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU as a
// multi-cycle shift-add multiplier / restoring divider, stalling the pipeline
// whenever a HI/LO instruction arrives while an operation is in flight.
module muldiv_unit #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IssueValid,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic [31:0] HiLoOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [5:0] R_FORM = 6'h00;
    localparam logic [5:0] MFHI   = 6'h10;
    localparam logic [5:0] MTHI   = 6'h11;
    localparam logic [5:0] MFLO   = 6'h12;
    localparam logic [5:0] MTLO   = 6'h13;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] MULTU  = 6'h19;
    localparam logic [5:0] DIV    = 6'h1a;
    localparam logic [5:0] DIVU   = 6'h1b;

    localparam int N     = 32 / BITS_PER_CYCLE;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic [31:0]        c_q, c_d;
    logic               op_mul_q, op_mul_d;
    logic               op_signed_q, op_signed_d;
    logic               neg1_q, neg1_d;
    logic               neg2_q, neg2_d;
    logic               div0_q, div0_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_arith;
    logic        is_hilo;
    logic        busy;
    logic        accept;
    logic        unused_ins;

    logic        is_signed_op;
    logic [31:0] mag1;
    logic [31:0] mag2;

    logic [63:0] a_step;
    logic [63:0] b_step;
    logic [31:0] c_step;
    logic [32:0] rem_shift;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign opcode     = Ins[31:26];
    assign funct      = Ins[5:0];
    assign unused_ins = ^Ins[25:6];

    // Decode which instructions belong to this unit
    always_comb begin
        is_arith = (opcode == R_FORM) &&
                   (funct == MULT || funct == MULTU || funct == DIV || funct == DIVU);
        is_hilo  = is_arith ||
                   ((opcode == R_FORM) &&
                    (funct == MTHI || funct == MTLO || funct == MFHI || funct == MFLO));
    end

    assign busy   = (state_q != S_IDLE);
    assign Busy   = busy;
    assign Stall  = RST & IssueValid & is_hilo & busy;
    assign accept = IssueValid & is_hilo & ~busy & ~Flush;
    assign HI     = hi_q;
    assign LO     = lo_q;

    // Move-from reads are combinational so an unstalled MFHI/MFLO sees HI/LO now
    always_comb begin
        HiLoOut = 32'd0;
        if (RST && IssueValid && opcode == R_FORM) begin
            if (funct == MFHI)
                HiLoOut = hi_q;
            else if (funct == MFLO)
                HiLoOut = lo_q;
        end
    end

    // Operand magnitudes: signed ops iterate on |x| and fix the sign at the end
    always_comb begin
        is_signed_op = (funct == MULT) || (funct == DIV);
        mag1 = (is_signed_op && Rdata1[31]) ? (32'd0 - Rdata1) : Rdata1;
        mag2 = (is_signed_op && Rdata2[31]) ? (32'd0 - Rdata2) : Rdata2;
    end

    // BITS_PER_CYCLE shift-add or restoring-divide steps chained in one cycle
    always_comb begin
        a_step    = a_q;
        b_step    = b_q;
        c_step    = c_q;
        rem_shift = 33'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_mul_q) begin
                if (c_step[0])
                    a_step = a_step + b_step;
                b_step = {b_step[62:0], 1'b0};
                c_step = {1'b0, c_step[31:1]};
            end else begin
                rem_shift = a_step[63:31];
                a_step    = {a_step[62:0], 1'b0};
                if (rem_shift >= {1'b0, b_step[31:0]}) begin
                    a_step[63:32] = rem_shift[31:0] - b_step[31:0];
                    a_step[0]     = 1'b1;
                end
            end
        end
    end

    // Sign correction applied in FIX; remainder follows the dividend's sign
    always_comb begin
        prod_fix = (op_signed_q && (neg1_q ^ neg2_q)) ? (64'd0 - a_q) : a_q;
        quo_fix  = (op_signed_q && (neg1_q ^ neg2_q)) ? (32'd0 - a_q[31:0]) : a_q[31:0];
        rem_fix  = (op_signed_q && neg1_q) ? (32'd0 - a_q[63:32]) : a_q[63:32];
    end

    // Next-state logic for the IDLE -> CALC -> FIX sequence and HI/LO writes
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        op_mul_d    = op_mul_q;
        op_signed_d = op_signed_q;
        neg1_d      = neg1_q;
        neg2_d      = neg2_q;
        div0_d      = div0_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (funct == MTHI) begin
                        hi_d = Rdata1;
                    end else if (funct == MTLO) begin
                        lo_d = Rdata1;
                    end else if (is_arith) begin
                        op_mul_d    = (funct == MULT) || (funct == MULTU);
                        op_signed_d = is_signed_op;
                        neg1_d      = is_signed_op & Rdata1[31];
                        neg2_d      = is_signed_op & Rdata2[31];
                        cnt_d       = '0;
                        div0_d      = 1'b0;
                        if (funct == MULT || funct == MULTU) begin
                            a_d     = 64'd0;
                            b_d     = {32'd0, mag1};
                            c_d     = mag2;
                            state_d = S_CALC;
                        end else if (Rdata2 == 32'd0) begin
                            div0_d  = 1'b1;
                            a_d     = {Rdata1, 32'hFFFF_FFFF};
                            state_d = S_FIX;
                        end else begin
                            a_d     = {32'd0, mag1};
                            b_d     = {32'd0, mag2};
                            c_d     = 32'd0;
                            state_d = S_CALC;
                        end
                    end
                end
            end
            S_CALC: begin
                if (Flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    a_d = a_step;
                    b_d = b_step;
                    c_d = c_step;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Flush) begin
                    if (div0_q) begin
                        hi_d = a_q[63:32];
                        lo_d = a_q[31:0];
                    end else if (op_mul_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operation and clears HI/LO
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            c_q         <= 32'd0;
            op_mul_q    <= 1'b0;
            op_signed_q <= 1'b0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            div0_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            op_mul_q    <= op_mul_d;
            op_signed_q <= op_signed_d;
            neg1_q      <= neg1_d;
            neg2_q      <= neg2_d;
            div0_q      <= div0_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed HI/LO instruction sequences with a scoreboard that
// checks HI/LO and the busy duration each time an operation completes.
module tb_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADD   = 6'h20;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic        IssueValid;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic        Flush;
    logic        Stall;
    logic        Busy;
    logic [31:0] HiLoOut;
    logic [31:0] HI;
    logic [31:0] LO;

    logic        rst4;
    logic        iv4;
    logic [31:0] ins4;
    logic [31:0] r1_4;
    logic [31:0] r2_4;
    logic        stall4;
    logic        busy4;
    logic [31:0] hilo4;
    logic [31:0] hi4;
    logic [31:0] lo4;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cycles = 0;
    bit   busy_prev = 1'b0;

    muldiv_unit #(.BITS_PER_CYCLE(1)) dut (
        .CLK(CLK), .RST(RST), .IssueValid(IssueValid), .Ins(Ins),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Flush(Flush), .Stall(Stall),
        .Busy(Busy), .HiLoOut(HiLoOut), .HI(HI), .LO(LO)
    );

    muldiv_unit #(.BITS_PER_CYCLE(4)) dut4 (
        .CLK(CLK), .RST(rst4), .IssueValid(iv4), .Ins(ins4),
        .Rdata1(r1_4), .Rdata2(r2_4), .Flush(1'b0), .Stall(stall4),
        .Busy(busy4), .HiLoOut(hilo4), .HI(hi4), .LO(lo4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Safety net so a hung handshake still ends the run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rIns(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: each time Busy falls, pop the expected result and compare
    always @(negedge CLK) begin
        if (!RST) begin
            busy_cycles = 0;
            busy_prev   = 1'b0;
        end else begin
            if (Busy) begin
                busy_cycles++;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got completion, expected none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("sb_hi", HI, e.hi);
                    checkOutput("sb_lo", LO, e.lo);
                    checkOutput("sb_busy_cycles", 32'(busy_cycles), 32'(e.cycles));
                end
                busy_cycles = 0;
            end
            busy_prev = Busy;
        end
    end

    // Present an instruction, hold it while stalled, push its expectation
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] r1,
                                 input logic [31:0] r2, input bit push,
                                 input logic [31:0] eh, input logic [31:0] el,
                                 input int ecyc);
        int waited;
        waited     = 0;
        IssueValid = 1'b1;
        Ins        = rIns(f);
        Rdata1     = r1;
        Rdata2     = r2;
        @(negedge CLK);
        while (Stall && waited < 200) begin
            waited++;
            @(negedge CLK);
        end
        if (Stall) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue_timeout: got Stall=1 after %0d cycles, expected release", waited);
        end
        if (push)
            sb.push_back('{eh, el, ecyc});
        @(posedge CLK);
        #1;
        IssueValid = 1'b0;
        Ins        = 32'd0;
    endtask

    // Issue MFHI/MFLO, count stalled cycles, check the value once released
    task automatic readHiLo(input string name, input logic [5:0] f,
                            input logic [31:0] expv, input int exp_stall);
        int n;
        n          = 0;
        IssueValid = 1'b1;
        Ins        = rIns(f);
        @(negedge CLK);
        while (Stall && n < 200) begin
            n++;
            @(negedge CLK);
        end
        checkOutput({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        checkOutput({name, "_value"}, HiLoOut, expv);
        @(posedge CLK);
        #1;
        IssueValid = 1'b0;
        Ins        = 32'd0;
    endtask

    // Wait for the BITS_PER_CYCLE=4 instance to finish, return busy length
    task automatic runDut4(input logic [5:0] f, input logic [31:0] r1,
                           input logic [31:0] r2, output int cnt);
        cnt  = 0;
        iv4  = 1'b1;
        ins4 = rIns(f);
        r1_4 = r1;
        r2_4 = r2;
        @(posedge CLK);
        #1;
        iv4 = 1'b0;
        forever begin
            @(negedge CLK);
            if (!busy4 || cnt >= 100)
                break;
            cnt++;
        end
    endtask

    // Directed sequence
    initial begin
        int c4;
        RST        = 1'b1;
        rst4       = 1'b1;
        IssueValid = 1'b0;
        Ins        = 32'd0;
        Rdata1     = 32'd0;
        Rdata2     = 32'd0;
        Flush      = 1'b0;
        iv4        = 1'b0;
        ins4       = 32'd0;
        r1_4       = 32'd0;
        r2_4       = 32'd0;
        #1;
        RST  = 1'b0;
        rst4 = 1'b0;
        IssueValid = 1'b1;
        Ins        = rIns(F_MFHI);
        #1;
        checkOutput("reset_busy", 32'(Busy), 32'd0);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        checkOutput("reset_stall", 32'(Stall), 32'd0);
        checkOutput("reset_hilo_out", HiLoOut, 32'd0);
        IssueValid = 1'b0;
        Ins        = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST  = 1'b1;
        rst4 = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] MULT -5*7 with MFLO issued while busy");
        applyStimulus(F_MULT, 32'hFFFF_FFFB, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 33);
        repeat (4) @(posedge CLK);
        #1;
        readHiLo("mflo_after_mult", F_MFLO, 32'hFFFF_FFDD, 29);

        $display("[TB] arithmetic vectors");
        applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        applyStimulus(F_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 33);
        applyStimulus(F_DIVU, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1);
        applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 33);
        applyStimulus(F_DIV, 32'd50, 32'd0, 1'b1, 32'd50, 32'hFFFF_FFFF, 1);
        applyStimulus(F_MULT, 32'h0001_0000, 32'hFFFF_8000, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 33);

        $display("[TB] MTHI/MTLO while idle");
        applyStimulus(F_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        checkOutput("mthi_hi", HI, 32'hA5A5_A5A5);
        applyStimulus(F_MTLO, 32'h3C3C_3C3C, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        checkOutput("mtlo_lo", LO, 32'h3C3C_3C3C);
        checkOutput("mtlo_hi_kept", HI, 32'hA5A5_A5A5);
        readHiLo("mfhi_idle", F_MFHI, 32'hA5A5_A5A5, 0);
        readHiLo("mflo_idle", F_MFLO, 32'h3C3C_3C3C, 0);

        $display("[TB] flush during DIV");
        applyStimulus(F_DIV, 32'd1000, 32'd3, 1'b1, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 11);
        IssueValid = 1'b1;
        Ins        = rIns(F_ADD);
        @(negedge CLK);
        checkOutput("nonhilo_stall", 32'(Stall), 32'd0);
        checkOutput("nonhilo_hilo_out", HiLoOut, 32'd0);
        IssueValid = 1'b0;
        Ins        = 32'd0;
        repeat (10) @(posedge CLK);
        #1;
        Flush = 1'b1;
        @(posedge CLK);
        #1;
        Flush = 1'b0;
        checkOutput("flush_busy", 32'(Busy), 32'd0);
        applyStimulus(F_MULT, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 33);

        $display("[TB] reset in the middle of MULT");
        applyStimulus(F_MULT, 32'd6, 32'd7, 1'b0, 32'd0, 32'd0, 0);
        repeat (20) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(Busy), 32'd0);
        checkOutput("midreset_hi", HI, 32'd0);
        checkOutput("midreset_lo", LO, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        readHiLo("mflo_after_reset", F_MFLO, 32'd0, 0);

        $display("[TB] BITS_PER_CYCLE=4 instance");
        runDut4(F_MULT, 32'hFFFF_FFFB, 32'd7, c4);
        checkOutput("bpc4_mult_busy_cycles", 32'(c4), 32'd9);
        checkOutput("bpc4_mult_hi", hi4, 32'hFFFF_FFFF);
        checkOutput("bpc4_mult_lo", lo4, 32'hFFFF_FFDD);
        @(posedge CLK);
        #1;
        runDut4(F_DIVU, 32'd100, 32'd7, c4);
        checkOutput("bpc4_divu_busy_cycles", 32'(c4), 32'd9);
        checkOutput("bpc4_divu_hi", hi4, 32'd2);
        checkOutput("bpc4_divu_lo", lo4, 32'd14);

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide controller that owns the architectural HI/LO registers for the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the EX stage, sequences an iterative shift-add multiplier and restoring divider, and raises a pipeline stall whenever a HI/LO instruction issues while an operation is still in flight. The single-cycle HI/LO arithmetic in EX is replaced by this unit.

## Interface
- BITS_PER_CYCLE, 1, iteration steps per clock. Legal values are 1, 2 or 4. CALC lasts N = 32/BITS_PER_CYCLE cycles.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset (asserted at 0).
- IssueValid  in  1  Ins/Rdata1/Rdata2 hold a live EX-stage instruction this cycle.
- Ins  in  32  instruction; opcode/funct decoded with the shared common_param.vh names (R_FORM, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- Rdata1  in  32  rs value (multiplicand/dividend; source for MTHI/MTLO).
- Rdata2  in  32  rt value (multiplier/divisor).
- Flush  in  1  abort any in-flight operation; HI/LO are left unchanged.
- Stall  out  1  combinational; the pipeline must hold EX and earlier stages.
- Busy  out  1  registered; an operation is in CALC or FIX.
- HiLoOut  out  32  combinational; HI for MFHI, LO for MFLO, else 0.
- HI, LO  out  32 each  architectural registers (for debug/trace).

## Operation
- HiLo op = R_FORM with funct in {MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO}. Arith op = first four.
- Stall = RST & IssueValid & HiLo op & Busy. Accept = IssueValid & HiLo op & ~Busy & ~Flush.
- FSM IDLE -> CALC -> FIX -> IDLE:
  - IDLE: on Accept of an arith op, latch the operand magnitudes (|x| for signed ops), the result-sign flags and the op type, clear the counter, and go to CALC. DIV/DIVU with Rdata2==0 goes directly to FIX with the div0 flag set. MTHI/MTLO write HI/LO at the accepting edge and stay in IDLE.
  - CALC: each edge performs BITS_PER_CYCLE steps. Multiply: 64-bit shift-add, unsigned magnitudes. Divide: restoring, 32 quotient bits MSB first. After N cycles go to FIX.
  - FIX: one cycle. Apply the signs (signed mult: negate the 64-bit product if the signs differ; signed div: quotient negative if the signs differ, remainder takes the dividend's sign). Write {HI,LO} = product, or HI = remainder and LO = quotient. On the next edge go to IDLE.
- Divide by zero (both DIV and DIVU): LO = 32'hFFFFFFFF, HI = Rdata1 (raw dividend).
- DIV 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural magnitude result, no trap).
- MFHI/MFLO when not busy: HiLoOut shows the current HI/LO; there is no stall.
- Non-HiLo instructions never stall and are ignored.
- Flush: from CALC or FIX, go to IDLE at the next edge with no HI/LO write. Flush in IDLE blocks acceptance that cycle.

## Timing
- Reset (RST=0, asynchronous): state IDLE, counter 0, HI=0, LO=0, Busy=0. Stall=0 and HiLoOut=0 while reset is asserted.
- Arith op accepted at edge E: Busy=1 from after E until after edge E+N+1.
  - HI/LO are written at edge E+N+1 and Busy falls at the same edge.
  - Default N=32 gives a write at E+33.
- Divide by zero: write at E+1, Busy high for one cycle.
- A stalled HiLo instruction is held by the pipeline. It is accepted, or read with no stall, in the first cycle in which Busy=0, which is the cycle after the write edge. HiLoOut then shows the new value.
- No forwarding from FIX; MFHI/MFLO always wait for the write to complete.
- Reset asserted mid-operation: immediate IDLE, HI/LO cleared, operation lost.

## Test plan
- MULT Rdata1=-5 (0xFFFFFFFB), Rdata2=7, accepted at edge E -> Busy=1 for 33 cycles; at E+33 HI=0xFFFFFFFF, LO=0xFFFFFFDD.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- DIVU 0x12345678/0, accepted at E -> at E+1 LO=0xFFFFFFFF, HI=0x12345678, and Busy=1 for exactly one cycle.
- MFLO issued at E+5 after a MULT -> Stall=1 for cycles E+5..E+33; at E+34 Stall=0 and HiLoOut=new LO. MTHI 0xA5A5A5A5 while idle -> HI updated at the next edge with no stall.
- Flush asserted at E+10 of a DIV -> IDLE at E+11, HI/LO keep their prior values, and a following MULT is accepted normally.
- RST driven low at E+20 of a MULT, asynchronously -> Busy=0, HI=LO=0 immediately. Repeat with BITS_PER_CYCLE=4 -> write at E+9 with the same values.
